// File: rtl/aoi222_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : aoi222_rr_arbiter
// Brief   : Round-robin one-hot select generator for a shared AOI222 3:1 mux,
//           with a break-before-make gap and bounded hold under contention.
// Rev     : 1.0
// ============================================================================
module aoi222_rr_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_a_i,
  input  logic       req_b_i,
  input  logic       req_c_i,
  input  logic       done_i,
  output logic       sel_a_o,
  output logic       sel_b_o,
  output logic       sel_c_o,
  output logic [1:0] gnt_id_o,
  output logic       busy_o,
  inout  wire        vdd_io,
  inout  wire        vss_io
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [1:0]       ID_NONE   = 2'd3;
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       own_d;

  logic [3:0] req_vec;
  logic [1:0] cand0, cand1, cand2;
  logic       win_vld;
  logic [1:0] win_id;
  logic       own_req;
  logic       other_req;
  logic       release_grant;

  // Power pins only connect the cell; they carry no logic function here.
  wire w_unused_pwr = vdd_io ^ vss_io;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] id);
    logic [2:0] oh;
    oh = 3'b000;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign req_vec = {1'b0, req_c_i, req_b_i, req_a_i};

  // Scan from the pointer, wrapping A->B->C->A.
  always_comb begin
    cand0   = ptr_q;
    cand1   = next_id(cand0);
    cand2   = next_id(cand1);
    win_vld = 1'b1;
    win_id  = ID_NONE;
    if (req_vec[cand0])      win_id = cand0;
    else if (req_vec[cand1]) win_id = cand1;
    else if (req_vec[cand2]) win_id = cand2;
    else                     win_vld = 1'b0;
  end

  assign own_req       = req_vec[gnt_q];
  assign other_req     = |({req_c_i, req_b_i, req_a_i} & ~onehot3(gnt_q));
  assign release_grant = done_i || !own_req || ((cnt_q >= HOLD_LAST) && other_req);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      sel_q   <= 3'b000;
      gnt_q   <= ID_NONE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    own_d   = gnt_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        cnt_d = '0;
        if (win_vld) begin
          state_d = ST_GRANT;
          own_d   = win_id;
        end else begin
          state_d = ST_IDLE;
          own_d   = ID_NONE;
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          state_d = ST_GAP;
          ptr_d   = next_id(gnt_q);
          cnt_d   = '0;
          own_d   = ID_NONE;
        end else if (cnt_q != HOLD_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        own_d   = ID_NONE;
      end
    endcase
  end

  // Output logic: selects and grant id are derived from the upcoming state.
  always_comb begin
    sel_d = 3'b000;
    gnt_d = ID_NONE;
    if (state_d == ST_GRANT) begin
      sel_d = onehot3(own_d);
      gnt_d = own_d;
    end
  end

  assign sel_a_o  = sel_q[0];
  assign sel_b_o  = sel_q[1];
  assign sel_c_o  = sel_q[2];
  assign gnt_id_o = gnt_q;
  assign busy_o   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aoi222_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_aoi222_rr_arbiter
// Brief   : Self-checking bench for aoi222_rr_arbiter against a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_aoi222_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, req_c = 1'b0, done = 1'b0;
  logic       sel_a, sel_b, sel_c;
  logic [1:0] gnt_id;
  logic       busy;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: mode 0=idle 1=granted 2=gap; held = cycles the owner has had the net
  int m_mode  = 0;
  int m_owner = 3;
  int m_ptr   = 0;
  int m_held  = 0;

  aoi222_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_a_i (req_a),
    .req_b_i (req_b),
    .req_c_i (req_c),
    .done_i  (done),
    .sel_a_o (sel_a),
    .sel_b_o (sel_b),
    .sel_c_o (sel_c),
    .gnt_id_o(gnt_id),
    .busy_o  (busy),
    .vdd_io  (vdd),
    .vss_io  (vss)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0] r;
    int w;
    bit others;
    r = {req_c, req_b, req_a};
    if (rst) begin
      m_mode = 0; m_owner = 3; m_ptr = 0; m_held = 0;
      return;
    end
    if (m_mode == 1) begin
      others = 1'b0;
      for (int j = 0; j < 3; j++)
        if (j != m_owner && r[j]) others = 1'b1;
      if (done || !r[m_owner] || (m_held >= MAX_HOLD && others)) begin
        m_mode = 2; m_ptr = (m_owner + 1) % 3; m_owner = 3; m_held = 0;
      end else begin
        m_held++;
      end
    end else begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_mode = 1; m_owner = w; m_held = 1;
      end else begin
        m_mode = 0; m_owner = 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] r);
    {req_c, req_b, req_a} = r;
  endtask

  always @(negedge clk) begin
    logic [2:0] exp_sel;
    logic [2:0] act_sel;
    if (chk_en) begin
      act_sel = {sel_c, sel_b, sel_a};
      exp_sel = (m_mode == 1) ? (3'b001 << m_owner) : 3'b000;
      check("model_sel", act_sel, exp_sel);
      check("model_gnt_id", gnt_id, (m_mode == 1) ? m_owner : 3);
      check("model_busy", busy, (m_mode != 0) ? 1 : 0);
      check("sel_onehot", ($countones(act_sel) <= 1) ? 1 : 0, 1);
    end
  end

  initial begin
    logic [2:0] exp;

    // Reset with every request high
    rst = 1'b1; set_req(3'b111); done = 1'b0;
    tick(); chk_en = 1'b1; tick();
    check("rst_sel", {sel_c, sel_b, sel_a}, 3'b000);
    check("rst_gnt", gnt_id, 2'd3);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_release_a", {sel_c, sel_b, sel_a}, 3'b001);

    // Round robin with DONE per grant: A gap B gap C gap A
    done = 1'b1; tick(); check("rr_gap1", {sel_c, sel_b, sel_a}, 3'b000);
    done = 1'b0; tick(); check("rr_b", {sel_c, sel_b, sel_a}, 3'b010);
    done = 1'b1; tick(); check("rr_gap2", {sel_c, sel_b, sel_a}, 3'b000);
    done = 1'b0; tick(); check("rr_c", {sel_c, sel_b, sel_a}, 3'b100);
    done = 1'b1; tick(); check("rr_gap3", {sel_c, sel_b, sel_a}, 3'b000);
    done = 1'b0; tick(); check("rr_a", {sel_c, sel_b, sel_a}, 3'b001);
    check("rr_a_id", gnt_id, 2'd0);

    // Preemption: A and C held, no DONE
    rst = 1'b1; tick(); rst = 1'b0; set_req(3'b101);
    for (int i = 0; i < 11; i++) begin
      tick();
      exp = (i < 4) ? 3'b001 : (i == 4) ? 3'b000 : (i < 9) ? 3'b100 : (i == 9) ? 3'b000 : 3'b001;
      check("preempt_seq", {sel_c, sel_b, sel_a}, exp);
    end

    // Sole requester past the hold limit keeps the grant
    rst = 1'b1; tick(); rst = 1'b0; set_req(3'b100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("sole_c_hold", {sel_c, sel_b, sel_a}, 3'b100);
    end

    // Single request B with DONE
    rst = 1'b1; tick(); rst = 1'b0; set_req(3'b010);
    tick(); check("single_b", {sel_c, sel_b, sel_a}, 3'b010);
    tick();
    done = 1'b1; set_req(3'b000);
    tick(); check("single_gap", {sel_c, sel_b, sel_a}, 3'b000);
    check("single_gap_busy", busy, 1'b1);
    done = 1'b0;
    tick(); check("single_idle_busy", busy, 1'b0);

    // Mid-grant reset, then pointer back at A
    set_req(3'b010); tick();
    check("mid_b", {sel_c, sel_b, sel_a}, 3'b010);
    rst = 1'b1; tick();
    check("mid_rst_sel", {sel_c, sel_b, sel_a}, 3'b000);
    check("mid_rst_gnt", gnt_id, 2'd3);
    rst = 1'b0; set_req(3'b111); tick();
    check("mid_ptr_a", {sel_c, sel_b, sel_a}, 3'b001);

    // Dropped request releases the grant
    set_req(3'b110); tick();
    check("drop_gap", {sel_c, sel_b, sel_a}, 3'b000);
    tick();
    check("drop_next_b", {sel_c, sel_b, sel_a}, 3'b010);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(7) == 0) req_b = ~req_b;
      if ($urandom_range(7) == 0) req_c = ~req_c;
      done = ($urandom_range(5) == 0);
      rst  = ($urandom_range(149) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
